// File: rtl/jkscan_seq_if.sv
// Bus between the scan sequencer and its environment: start/pattern handshake,
// scan pins to the JK bank and the unloaded result word (plus compare signals with JKSCAN_CMP_EN).
`timescale 1ns/1ps
interface jkscan_seq_if #(parameter int N = 8);
    logic         START;
    logic [N-1:0] PAT;
    logic         SO;
    logic         TEST;
    logic         SCANIN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] RESULT;
`ifdef JKSCAN_CMP_EN
    logic [N-1:0] EXPECT;
    logic         MISMATCH;

    modport master (output START, PAT, SO, EXPECT,
                    input  TEST, SCANIN, BUSY, DONE, RESULT, MISMATCH);
    modport slave  (input  START, PAT, SO, EXPECT,
                    output TEST, SCANIN, BUSY, DONE, RESULT, MISMATCH);
`else
    modport master (output START, PAT, SO,
                    input  TEST, SCANIN, BUSY, DONE, RESULT);
    modport slave  (input  START, PAT, SO,
                    output TEST, SCANIN, BUSY, DONE, RESULT);
`endif
endinterface

// File: rtl/jkscan_seq.sv
// Scan sequencer for a JK register bank: shift a pattern in, capture, shift out into RESULT.
// Optional result compare (EXPECT/MISMATCH) is built when JKSCAN_CMP_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for START; pattern latched on acceptance
//  LOAD   | N cycles, TEST=1, SCANIN = pattern MSB first
//  CAPT   | CAP_CYC cycles, TEST=0, bank does functional JK updates
//  UNLOAD | N cycles, TEST=1, SCANIN=0, SO shifted into RESULT
//  FIN    | 1 cycle, DONE pulse, RESULT valid
`timescale 1ns/1ps
module jkscan_seq #(
    parameter int N       = 8,
    parameter int CAP_CYC = 1
) (
    input  logic        CLK,
    input  logic        CLR,
    jkscan_seq_if.slave bus
);
    localparam int              CNTW     = $clog2(N) + 1;
    localparam logic [CNTW-1:0] BIT_LAST = CNTW'(N - 1);
    localparam logic [3:0]      CAP_LAST = 4'(CAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPT,
        S_UNLOAD,
        S_FIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] bit_cnt;
    logic [3:0]      cap_cnt;
    logic [N-2:0]    pat_sh;
    logic            bit_last;
    logic            cap_last;
    logic            test_r,  scanin_r,  busy_r,  done_r;
    logic            test_nxt, scanin_nxt, busy_nxt, done_nxt;
    logic [N-1:0]    result_r;
    logic [N-1:0]    result_nxt;

    assign bit_last   = (bit_cnt == BIT_LAST);
    assign cap_last   = (cap_cnt == CAP_LAST);
    assign result_nxt = {result_r[N-2:0], bus.SO};

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.START) state_nxt = S_LOAD;
            S_LOAD:   if (bit_last)  state_nxt = S_CAPT;
            S_CAPT:   if (cap_last)  state_nxt = S_UNLOAD;
            S_UNLOAD: if (bit_last)  state_nxt = S_FIN;
            S_FIN:                   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered pins; SCANIN leads the bank by one cycle
    always_comb begin
        test_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_UNLOAD);
        busy_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_CAPT) || (state_nxt == S_UNLOAD);
        done_nxt   = (state_nxt == S_FIN);
        scanin_nxt = 1'b0;
        if (state == S_IDLE && bus.START) begin
            scanin_nxt = bus.PAT[N-1];
        end else if (state == S_LOAD && !bit_last) begin
            scanin_nxt = pat_sh[N-2];
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            test_r   <= 1'b0;
            scanin_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            pat_sh   <= '0;
            bit_cnt  <= '0;
            cap_cnt  <= '0;
        end else begin
            test_r   <= test_nxt;
            scanin_r <= scanin_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.START) pat_sh <= bus.PAT[N-2:0];
                end
                S_LOAD: begin
                    pat_sh  <= pat_sh << 1;
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                end
                S_CAPT: begin
                    cap_cnt <= cap_last ? '0 : cap_cnt + 1'b1;
                end
                S_UNLOAD: begin
                    result_r <= result_nxt;
                    bit_cnt  <= bit_last ? '0 : bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.TEST   = test_r;
    assign bus.SCANIN = scanin_r;
    assign bus.BUSY   = busy_r;
    assign bus.DONE   = done_r;
    assign bus.RESULT = result_r;

`ifdef JKSCAN_CMP_EN
    logic [N-1:0] exp_r;
    logic         mismatch_r;

    // Compare uses the final shifted word so MISMATCH is valid together with DONE
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            exp_r      <= '0;
            mismatch_r <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.START) exp_r <= bus.EXPECT;
            if (state == S_UNLOAD && bit_last) mismatch_r <= (result_nxt != exp_r);
        end
    end

    assign bus.MISMATCH = mismatch_r;
`endif
endmodule
